auth_req_ctrl: RTL

AUTH_REQ_CTRL -- requirements
Module: auth_req_ctrl

---
 rtl/auth_pkg.sv | 15 +
 rtl/auth_timer.sv | 43 ++++
 rtl/auth_req_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/auth_pkg.sv
// Shared types and defaults for the auth request controller.
// Holds the FSM state encoding and the default CNT_W / MAX_RETRY values.
package auth_pkg;

    localparam int AUTH_CNT_W     = 32;
    localparam int AUTH_MAX_RETRY = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_TX  = 2'd2,
        WAIT_RSP = 2'd3
    } auth_state_e;

endpackage

// File: rtl/auth_timer.sv
// Response-wait timer: synchronous clear, count enable, saturation at
// all-ones, and an expire flag raised on the last allowed wait cycle.
// Ports: clk, rst_n (async active-low), clr, en, limit[CNT_W], expired.
module auth_timer
    import auth_pkg::*;
#(
    parameter int CNT_W = AUTH_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // limit is never zero, so limit-1 cannot underflow; hitting it
    // means exactly `limit` cycles have been spent waiting.
    assign expired = en && (cnt_q == (limit - ONE));

endmodule

// File: rtl/auth_req_ctrl.sv
// Auth request controller: sends the auth message, waits for a response
// with timeout and bounded resends, and reports done / Error_Busy pulses.
// Ports: clk, reset (async active-low), req_valid/req_ready, timeout_cfg,
// tx_start, tx_done, auth_msg_ready, done, Error_Busy, busy, retry_cnt.
// Optional: define AUTH_REQ_CTRL_ABORT_EN to add the abort input.
module auth_req_ctrl
    import auth_pkg::*;
#(
    parameter int CNT_W     = AUTH_CNT_W,
    parameter int MAX_RETRY = AUTH_MAX_RETRY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] timeout_cfg,
    output logic             tx_start,
    input  logic             tx_done,
    input  logic             auth_msg_ready,
`ifdef AUTH_REQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             done,
    output logic             Error_Busy,
    output logic             busy,
    output logic [1:0]       retry_cnt
);

    // Internal resend counter is wide enough for MAX_RETRY; the
    // reported value saturates at 3.
    localparam int RW = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]    RMAX = RW'(MAX_RETRY);
    localparam logic [RW-1:0]    RONE = RW'(1);
    localparam logic [RW-1:0]    RSAT = RW'(3);
    localparam logic [CNT_W-1:0] TONE = CNT_W'(1);

    auth_state_e      state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             expired;
    logic             abort_i;

`ifdef AUTH_REQ_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Timer runs only in WAIT_RSP and restarts from zero on every entry.
    auth_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (state_q != WAIT_RSP),
        .en      (state_q == WAIT_RSP),
        .limit   (tmo_q),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        tmo_d   = (timeout_cfg == '0) ? TONE : timeout_cfg;
                        retry_d = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    state_d = WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        state_d = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response in the expiring cycle still counts.
                    if (auth_msg_ready) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (expired) begin
                        if (retry_q < RMAX) begin
                            retry_d = retry_q + RONE;
                            state_d = SEND;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmo_q   <= TONE;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx_start   = (state_q == SEND);
    assign done       = done_q;
    assign Error_Busy = err_q;
    assign retry_cnt  = (retry_q > RSAT) ? 2'd3 : retry_q[1:0];

endmodule
